// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pkg
// Purpose  : Shared definitions for the unified-memory port arbiter: FSM state
//            encoding and requester identifiers.
// Revision : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ACCESS  = 2'b01,
        RESPOND = 2'b10
    } arb_state_t;

    // Requester identifiers double as the round-robin grant encoding.
    localparam logic REQ_CORE   = 1'b0;
    localparam logic REQ_LOADER = 1'b1;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter_if
// Purpose  : Bundles the two requester handshakes and the memory macro port.
//   r0_* : multicycle core (req/we/addr/wdata in, ack/rdata out)
//   r1_* : program loader / debug port, same shape as r0_*
//   mem_*: memory macro port (en/we/addr/wdata out, rdata in)
//   busy : arbiter not in IDLE
//   Modport slave  : arbiter side.
//   Modport master : requesters + memory side (environment).
// Revision : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              r0_req;
    logic              r0_we;
    logic [ADDR_W-1:0] r0_addr;
    logic [DATA_W-1:0] r0_wdata;
    logic              r0_ack;
    logic [DATA_W-1:0] r0_rdata;

    logic              r1_req;
    logic              r1_we;
    logic [ADDR_W-1:0] r1_addr;
    logic [DATA_W-1:0] r1_wdata;
    logic              r1_ack;
    logic [DATA_W-1:0] r1_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;

    modport slave (
        input  r0_req, r0_we, r0_addr, r0_wdata,
        output r0_ack, r0_rdata,
        input  r1_req, r1_we, r1_addr, r1_wdata,
        output r1_ack, r1_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output busy
    );

    modport master (
        output r0_req, r0_we, r0_addr, r0_wdata,
        input  r0_ack, r0_rdata,
        output r1_req, r1_we, r1_addr, r1_wdata,
        input  r1_ack, r1_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  busy
    );

endinterface : mem_port_arbiter_if
`default_nettype wire

// File: rtl/mem_arb_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_rr_pick
// Purpose  : Combinational 2-way round-robin select.
//   req[1:0]   : request vector, bit i = requester i
//   last_grant : requester granted most recently
//   gnt_id     : requester to grant (valid when any_req)
//   any_req    : at least one request pending
// Revision : 1.0 - initial release
// ============================================================================
module mem_arb_rr_pick
    import mem_arb_pkg::*;
(
    input  wire [1:0] req,
    input  wire       last_grant,
    output logic      gnt_id,
    output logic      any_req
);

    always_comb begin
        any_req = |req;
        gnt_id  = REQ_CORE;
        if (req == 2'b11) begin
            // Tie: the requester that did not win last time goes next.
            gnt_id = ~last_grant;
        end else if (req[1]) begin
            gnt_id = REQ_LOADER;
        end
    end

endmodule : mem_arb_rr_pick
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one fixed-latency unified memory between the core (r0)
//            and the loader/debug port (r1) with req/ack handshakes and a
//            2-way round-robin grant. One access per MEM_LATENCY+2 cycles.
//   clk   : clock, all state updates on the rising edge
//   reset : synchronous, active-low
//   bus   : mem_port_arbiter_if.slave (requester handshakes, memory port,
//           busy)
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = 1
) (
    input  wire                clk,
    input  wire                reset,
    mem_port_arbiter_if.slave  bus
);

    // Guard keeps widths legal long enough for the check below to report.
    localparam int c_cnt_w = (MEM_LATENCY < 1) ? 1 : $clog2(MEM_LATENCY + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(MEM_LATENCY - 1);

    generate
        if (MEM_LATENCY < 1) begin : g_latency_check
            $error("mem_port_arbiter: MEM_LATENCY must be at least 1");
        end
    endgenerate

    arb_state_t         r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_last_grant;
    logic               r_gnt_id;
    logic               r_we;

    logic               w_gnt_id;
    logic               w_any_req;

    mem_arb_rr_pick u_rr_pick (
        .req        ({bus.r1_req, bus.r0_req}),
        .last_grant (r_last_grant),
        .gnt_id     (w_gnt_id),
        .any_req    (w_any_req)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_last_grant  <= REQ_LOADER;  // core wins the first tie
            r_gnt_id      <= REQ_CORE;
            r_we          <= 1'b0;
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.r0_ack    <= 1'b0;
            bus.r1_ack    <= 1'b0;
            bus.r0_rdata  <= '0;
            bus.r1_rdata  <= '0;
            bus.busy      <= 1'b0;
        end else begin
            // Acks are single-cycle pulses.
            bus.r0_ack <= 1'b0;
            bus.r1_ack <= 1'b0;

            case (r_state)
                IDLE: begin
                    bus.mem_en <= 1'b0;
                    bus.mem_we <= 1'b0;
                    if (w_any_req) begin
                        // Request fields are frozen here for the whole access.
                        r_gnt_id      <= w_gnt_id;
                        r_last_grant  <= w_gnt_id;
                        r_we          <= w_gnt_id ? bus.r1_we    : bus.r0_we;
                        bus.mem_we    <= w_gnt_id ? bus.r1_we    : bus.r0_we;
                        bus.mem_addr  <= w_gnt_id ? bus.r1_addr  : bus.r0_addr;
                        bus.mem_wdata <= w_gnt_id ? bus.r1_wdata : bus.r0_wdata;
                        bus.mem_en    <= 1'b1;
                        bus.busy      <= 1'b1;
                        r_cnt         <= '0;
                        r_state       <= ACCESS;
                    end
                end

                ACCESS: begin
                    r_cnt      <= r_cnt + c_cnt_w'(1);
                    // Write strobe only in the first ACCESS cycle.
                    bus.mem_we <= 1'b0;
                    if (r_cnt == c_cnt_last) begin
                        bus.mem_en <= 1'b0;
                        if (r_gnt_id == REQ_LOADER) begin
                            bus.r1_ack <= 1'b1;
                            if (!r_we) begin
                                bus.r1_rdata <= bus.mem_rdata;
                            end
                        end else begin
                            bus.r0_ack <= 1'b1;
                            if (!r_we) begin
                                bus.r0_rdata <= bus.mem_rdata;
                            end
                        end
                        r_state <= RESPOND;
                    end
                end

                RESPOND: begin
                    bus.busy <= 1'b0;
                    r_state  <= IDLE;
                end

                default: begin
                    bus.mem_en <= 1'b0;
                    bus.mem_we <= 1'b0;
                    bus.busy   <= 1'b0;
                    r_state    <= IDLE;
                end
            endcase
        end
    end

endmodule : mem_port_arbiter
`default_nettype wire
